// File: rtl/triangle_sweep_ctrl_if.sv
// Bus bundle for triangle_sweep_ctrl: config write port, start/stop
// commands and the sweep outputs. Optional pause input when PAUSE_EN
// is defined.
interface triangle_sweep_ctrl_if #(
  parameter int COUNTER_NOB = 11
);
  logic                   cfg_we;
  logic [1:0]             cfg_addr;
  logic [15:0]            cfg_wdata;
  logic                   cfg_err;
  logic                   start;
  logic                   stop;
  logic                   busy;
  logic                   done;
  logic                   peak;
  logic                   dir;
  logic [COUNTER_NOB-1:0] counter;
`ifdef PAUSE_EN
  logic                   pause;
`endif

  // Host / control side: issues writes and commands, observes the sweep.
  modport master (
    output cfg_we, cfg_addr, cfg_wdata, start, stop,
`ifdef PAUSE_EN
    output pause,
`endif
    input  cfg_err, busy, done, peak, dir, counter
  );

  // Controller side.
  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, start, stop,
`ifdef PAUSE_EN
    input  pause,
`endif
    output cfg_err, busy, done, peak, dir, counter
  );
endinterface

// File: rtl/triangle_sweep_ctrl.sv
// Triangle up/down sweep controller with run-time config registers
// (LOW, HIGH, tick divider, cycle count) and an IDLE/RUN sequencer.
// Optional feature macro: PAUSE_EN (adds a pause input that freezes
// the sweep while in RUN).
module triangle_sweep_ctrl #(
  parameter int COUNTER_NOB = 11,
  parameter int DIV_NOB     = 16,
  parameter int CYCLES_NOB  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  triangle_sweep_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [COUNTER_NOB-1:0] LOW_RST    = '0;
  localparam logic [COUNTER_NOB-1:0] HIGH_RST   = COUNTER_NOB'(10);
  localparam logic [DIV_NOB-1:0]     DIV_RST    = '0;
  localparam logic [CYCLES_NOB-1:0]  CYCLES_RST = CYCLES_NOB'(1);

  state_t                 state_reg;
  logic [COUNTER_NOB-1:0] low_reg;
  logic [COUNTER_NOB-1:0] high_reg;
  logic [DIV_NOB-1:0]     div_reg;
  logic [CYCLES_NOB-1:0]  cycles_reg;
  logic [COUNTER_NOB-1:0] counter_reg;
  logic                   dir_reg;
  logic [DIV_NOB-1:0]     divider_reg;
  logic [CYCLES_NOB-1:0]  cycle_cnt_reg;
  logic                   done_reg;
  logic                   cfg_err_reg;

  logic                   hold;
  logic                   tick;
  logic                   cfg_valid;
  logic [COUNTER_NOB-1:0] counter_next;
  logic                   dir_next;
  logic                   lands_low;
  logic [CYCLES_NOB-1:0]  cycle_cnt_next;
  logic                   cycle_finish;

`ifdef PAUSE_EN
  assign hold = bus.pause;
`else
  assign hold = 1'b0;
`endif

  // A start is only accepted when the window is non-empty.
  assign cfg_valid = (low_reg < high_reg);

  // Divider expiry marks a sweep step.
  assign tick = (divider_reg == '0);

  // Next sweep position: turn around at either bound, never wrap.
  always_comb begin
    counter_next = counter_reg;
    dir_next     = dir_reg;
    if (dir_reg) begin
      if (counter_reg == high_reg) begin
        dir_next     = 1'b0;
        counter_next = counter_reg - 1'b1;
      end else begin
        counter_next = counter_reg + 1'b1;
      end
    end else begin
      if (counter_reg == low_reg) begin
        dir_next     = 1'b1;
        counter_next = counter_reg + 1'b1;
      end else begin
        counter_next = counter_reg - 1'b1;
      end
    end
  end

  // A cycle ends on any downward step that lands on LOW (this includes the
  // turnaround from HIGH when the window is only two values wide).
  assign lands_low      = !dir_next && (counter_next == low_reg);
  assign cycle_cnt_next = (cycle_cnt_reg == '1) ? cycle_cnt_reg
                                                : cycle_cnt_reg + 1'b1;
  assign cycle_finish   = lands_low && (cycles_reg != '0) &&
                          (cycle_cnt_next == cycles_reg);

  // Sequencer, config registers and sweep state in one clocked block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      low_reg       <= LOW_RST;
      high_reg      <= HIGH_RST;
      div_reg       <= DIV_RST;
      cycles_reg    <= CYCLES_RST;
      counter_reg   <= '0;
      dir_reg       <= 1'b1;
      divider_reg   <= '0;
      cycle_cnt_reg <= '0;
      done_reg      <= 1'b0;
      cfg_err_reg   <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      cfg_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.cfg_we) begin
            case (bus.cfg_addr)
              2'd0: low_reg    <= bus.cfg_wdata[COUNTER_NOB-1:0];
              2'd1: high_reg   <= bus.cfg_wdata[COUNTER_NOB-1:0];
              2'd2: div_reg    <= bus.cfg_wdata[DIV_NOB-1:0];
              2'd3: cycles_reg <= bus.cfg_wdata[CYCLES_NOB-1:0];
            endcase
          end
          // Stop overrides start; a start against a bad window is flagged.
          if (bus.start && !bus.stop) begin
            if (cfg_valid) begin
              state_reg     <= RUN;
              counter_reg   <= low_reg;
              dir_reg       <= 1'b1;
              divider_reg   <= div_reg;
              cycle_cnt_reg <= '0;
            end else begin
              cfg_err_reg <= 1'b1;
            end
          end
        end
        RUN: begin
          // Config is locked while sweeping.
          if (bus.cfg_we) begin
            cfg_err_reg <= 1'b1;
          end
          if (bus.stop) begin
            // Abort: leave counter/dir where they are, no done.
            state_reg <= IDLE;
          end else if (!hold) begin
            if (tick) begin
              divider_reg <= div_reg;
              counter_reg <= counter_next;
              dir_reg     <= dir_next;
              if (lands_low) begin
                cycle_cnt_reg <= cycle_cnt_next;
              end
              if (cycle_finish) begin
                state_reg <= IDLE;
                done_reg  <= 1'b1;
              end
            end else begin
              divider_reg <= divider_reg - 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy    = (state_reg == RUN);
  assign bus.peak    = (state_reg == RUN) && (counter_reg == high_reg);
  assign bus.counter = counter_reg;
  assign bus.dir     = dir_reg;
  assign bus.done    = done_reg;
  assign bus.cfg_err = cfg_err_reg;

endmodule

// File: doc/triangle_sweep_ctrl.md
Name: triangle_sweep_ctrl

Overview:
Run-time-programmable controller for triangular up/down sweeps. Holds thresholds, tick divider and cycle count in config registers written over a simple write port. Sequences a bounded or continuous number of triangle cycles from start/stop commands. Sits between a control FSM or host register bank and the PWM/display consumers of the sweep value.

Parameters:
COUNTER_NOB, 11, width of sweep counter and threshold registers
DIV_NOB, 16, width of tick divider register
CYCLES_NOB, 8, width of cycle-count register

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cfg_we  in  1  config write strobe, one write per cycle
cfg_addr  in  2  0=LOW, 1=HIGH, 2=DIV, 3=CYCLES
cfg_wdata  in  16  write data, LSB-aligned, truncated to target register width
cfg_err  out  1  one-cycle pulse: write rejected, or start rejected
start  in  1  start sweep (level sampled each cycle)
stop  in  1  abort sweep
busy  out  1  high while in RUN
done  out  1  one-cycle pulse on normal completion
peak  out  1  high in RUN while counter==HIGH
dir  out  1  1=counting up
counter  out  COUNTER_NOB  sweep value

Behaviour:
- Reset values: LOW=0, HIGH=10, DIV=0, CYCLES=1, counter=0, dir=1, busy=0, done=0, cfg_err=0, state IDLE, cycle_cnt=0, divider=0.
- States: IDLE and RUN only. done and cfg_err are registered pulses.
- Config writes:
  - In IDLE: take effect next edge.
  - In RUN: ignored, cfg_err pulses next cycle.
- IDLE, start=1, stop=0:
  - Valid config (LOW<HIGH after truncation): next cycle RUN, counter=LOW, dir=1, divider=DIV, cycle_cnt=0.
  - Invalid config: stay IDLE, cfg_err pulses next cycle.
- IDLE, start and stop both 1: stop wins, no action.
- RUN divider:
  - tick when divider==0, then divider reloads DIV.
  - Otherwise divider decrements.
  - Tick period is DIV+1 clk cycles. First tick occurs in first RUN cycle when DIV=0.
- On tick:
  - dir=1, counter==HIGH: dir<=0, counter<=counter-1.
  - dir=1, otherwise: counter+1.
  - dir=0, counter==LOW: dir<=1, counter<=counter+1.
  - dir=0, otherwise: counter-1.
  - Counter never leaves [LOW,HIGH]. No wrap-around.
- Cycle completion: any tick whose downward step lands on LOW, including the turnaround from HIGH when HIGH==LOW+1. cycle_cnt increments, saturating at max.
  - CYCLES!=0 and incremented cycle_cnt==CYCLES: next state IDLE, done=1 that cycle, busy=0, counter holds LOW, dir=0.
  - CYCLES==0: continuous, never completes.
- start while in RUN: ignored.
- stop in RUN: next cycle IDLE. counter/dir hold last value. No done pulse. Stop has priority over a completion in the same cycle (no done).
- Reset mid-RUN: all registers to reset values next edge, including config. No done pulse.
- busy is combinational from state (high exactly in RUN cycles). peak is combinational: RUN && counter==HIGH.

Optional Feature:
PAUSE_EN: adds input port pause (1 bit).
- With macro: while pause=1 in RUN, divider, counter, dir and cycle_cnt freeze. busy stays 1. stop still aborts. pause is ignored in IDLE.
- Without macro: no pause port. Sweep runs uninterrupted.

Test Plan:
- Reset, write LOW=2, HIGH=5, DIV=0, CYCLES=1, pulse start at edge k -> counter 2,3,4,5,4,3 at k+1..k+6 with busy=1, peak=1 at k+4 only; k+7: counter=2, done=1, busy=0.
- LOW=3, HIGH=4, DIV=2, CYCLES=2 -> counter steps every 3 cycles: 3,4,3,4,3. done pulse on the cycle the second return to 3 appears. No value outside 3..4.
- CYCLES=0, LOW=0, HIGH=3, DIV=0, start, stop after 10 RUN cycles -> no done. Next cycle busy=0, counter holds value of last RUN cycle.
- Write LOW=7, HIGH=7, then start -> cfg_err one-cycle pulse, busy stays 0. Write cfg_addr=0 during RUN -> cfg_err pulse, LOW unchanged on the next sweep.
- Reset asserted mid-RUN -> next cycle counter=0, dir=1, busy=0, done=0. Start with no writes sweeps 0..10..0 and pulses done.
- PAUSE_EN build: pause=1 for 5 cycles mid-sweep at counter=4 -> counter stays 4, busy=1. Release -> sequence resumes with the same divider phase.
